// File: rtl/dcache_wb_buffer_pkg.sv
// ============================================================================
// Module : dcache_wb_buffer_pkg
// Brief  : Shared cache definitions used by the dcache write-back path:
//          line geometry, AXI size/burst encodings, AXI ID assignments and
//          the write-back buffer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dcache_wb_buffer_pkg;

  // Line geometry (32 B line, byte offset in addr[4:0])
  localparam int LINE_WORDS_DEFAULT = 8;
  localparam int OFFSET_BITS        = 5;

  // AXI encodings
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_STRB_ALL   = 4'hF;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI ID assignments per requester
  localparam logic [3:0] AXI_ID_ICACHE   = 4'd0;
  localparam logic [3:0] AXI_ID_DCACHE_RD = 4'd0;
  localparam logic [3:0] AXI_ID_DCACHE_WB = 4'd1;

  // Write-back buffer FSM
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_SEND = 2'd1,
    WB_RESP = 2'd2
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/dcache_wb_axi_w.sv
// ============================================================================
// Module : dcache_wb_axi_w
// Brief  : W-channel beat counter for the write-back buffer. Selects the word
//          being offered and flags the final beat of the burst.
// Ports  : clk, resetn  - clock / async active-low reset
//          start        - clear counter (new line accepted)
//          beat         - W handshake this cycle (wvalid & wready)
//          cnt          - index of the word currently offered
//          last         - cnt addresses the final word of the line
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_wb_axi_w #(
  parameter int LINE_WORDS = 8,
  localparam int CNT_W     = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             beat,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (beat) begin
      // Wraps to zero after the last beat; harmless since wvalid is then low.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(LINE_WORDS - 1));

endmodule

`default_nettype wire

// File: rtl/dcache_wb_buffer.sv
// ============================================================================
// Module : dcache_wb_buffer
// Brief  : Single-line write-back buffer. Captures an evicted dirty line and
//          drains it as one AXI INCR write burst, while exposing a line
//          address match so the dcache can stall a miss to the victim line.
// Ports  : clk, resetn                    - clock / async active-low reset
//          wb_valid, wb_ready, wb_addr,
//          wb_data                        - victim line hand-off from dcache
//          chk_addr, chk_hit              - in-flight line address match
//          busy                           - line held until B handshake
//          bus_err                        - pulse on non-OKAY B response
//          aw*, w*, b*                    - AXI write address/data/response
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import dcache_wb_buffer_pkg::*;

module dcache_wb_buffer #(
  parameter int         LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter logic [3:0] AXI_ID     = AXI_ID_DCACHE_WB
) (
  input  logic                    clk,
  input  logic                    resetn,
  // dcache side
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  logic [31:0]             wb_addr,
  input  logic [32*LINE_WORDS-1:0] wb_data,
  input  logic [31:0]             chk_addr,
  output logic                    chk_hit,
  output logic                    busy,
  output logic                    bus_err,
  // AXI AW
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI W
  output logic [3:0]              wid,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI B
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int CNT_W = $clog2(LINE_WORDS);

  wb_state_e                        state_q, state_d;
  logic [31:0]                      addr_q, addr_d;
  logic [LINE_WORDS-1:0][31:0]      line_q, line_d;
  logic                             aw_pend_q, aw_pend_d;
  logic                             w_pend_q, w_pend_d;

  logic [CNT_W-1:0]                 cnt;
  logic                             last_word;
  logic                             beat_start;
  logic                             aw_hs;
  logic                             w_hs;

  assign aw_hs = aw_pend_q & awready;
  assign w_hs  = w_pend_q & wready;

  dcache_wb_axi_w #(
    .LINE_WORDS (LINE_WORDS)
  ) u_axi_w (
    .clk    (clk),
    .resetn (resetn),
    .start  (beat_start),
    .beat   (w_hs),
    .cnt    (cnt),
    .last   (last_word)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    line_d     = line_q;
    beat_start = 1'b0;
    // AW and W retire independently; each pending flag drops after its own
    // final handshake and never re-arms until the next line is accepted.
    aw_pend_d  = aw_pend_q & ~aw_hs;
    w_pend_d   = w_pend_q & ~(w_hs & last_word);

    case (state_q)
      WB_IDLE: begin
        if (wb_valid) begin
          addr_d     = {wb_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          line_d     = wb_data;
          aw_pend_d  = 1'b1;
          w_pend_d   = 1'b1;
          beat_start = 1'b1;
          state_d    = WB_SEND;
        end
      end
      WB_SEND: begin
        // Covers AW-first, W-first and both completing in the same cycle.
        if (!aw_pend_d && !w_pend_d) begin
          state_d = WB_RESP;
        end
      end
      WB_RESP: begin
        if (bvalid) begin
          state_d = WB_IDLE;
        end
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= WB_IDLE;
      addr_q    <= '0;
      line_q    <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  // dcache side
  assign wb_ready = (state_q == WB_IDLE);
  assign busy     = (state_q != WB_IDLE);
  assign chk_hit  = busy && (chk_addr[31:OFFSET_BITS] == addr_q[31:OFFSET_BITS]);
  assign bus_err  = bready && bvalid && (bresp != AXI_RESP_OKAY);

  // AXI AW
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'(LINE_WORDS - 1);
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = aw_pend_q;

  // AXI W
  assign wid    = AXI_ID;
  assign wdata  = line_q[cnt];
  assign wstrb  = AXI_STRB_ALL;
  assign wlast  = last_word;
  assign wvalid = w_pend_q;

  // AXI B
  assign bready = (state_q == WB_RESP);

  // Response ID and line offsets are intentionally not used.
  logic unused_inputs;
  assign unused_inputs = ^{bid, wb_addr[OFFSET_BITS-1:0], chk_addr[OFFSET_BITS-1:0]};

endmodule

`default_nettype wire

// File: tb/tb_dcache_wb_buffer.sv
// ============================================================================
// Module : tb_dcache_wb_buffer
// Brief  : Self-checking bench for dcache_wb_buffer. A table of burst
//          scenarios is driven through a cycle-level AXI slave task, followed
//          by hand-written forwarding and mid-burst reset sequences.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dcache_wb_buffer;

  localparam int LW = 8;

  logic              clk;
  logic              resetn;
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_addr;
  logic [32*LW-1:0]  wb_data;
  logic [31:0]       chk_addr;
  logic              chk_hit;
  logic              busy;
  logic              bus_err;
  logic [3:0]        awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [3:0]        wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  dcache_wb_buffer #(
    .LINE_WORDS (LW),
    .AXI_ID     (4'd1)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .busy     (busy),
    .bus_err  (bus_err),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awvalid  (awvalid),
    .awready  (awready),
    .wid      (wid),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bid      (bid),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One burst scenario with its expected results.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] pat;        // word i = pat * (i+1)
    int          aw_delay;   // cycles awready held low after accept
    bit          rand_w;     // 50% wready
    bit          w_first;    // all W beats expected before AW handshake
    logic [1:0]  bresp;
    logic [31:0] exp_awaddr;
    bit          exp_err;
  } vec_t;

  function automatic logic [31:0] word_of(input logic [31:0] pat, input int idx);
    return 32'(pat * 32'(idx + 1));
  endfunction

  task automatic offer(input logic [31:0] addr, input logic [31:0] pat);
    int n;
    n = 0;
    while (!wb_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wb_ready before offer", wb_ready, 1);
    wb_valid = 1'b1;
    wb_addr  = addr;
    for (int i = 0; i < LW; i++) wb_data[32*i +: 32] = word_of(pat, i);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("awvalid one cycle after accept", awvalid, 1);
    chk("wvalid one cycle after accept", wvalid, 1);
  endtask

  task automatic do_burst(input vec_t v);
    int          beats;
    int          aws;
    int          cyc;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    chk_addr = {v.addr[31:5], 5'h1C};
    offer(v.addr, v.pat);
    chk("busy after accept", busy, 1);
    chk("wb_ready low in SEND", wb_ready, 0);
    chk("chk_hit on held line", chk_hit, 1);
    chk("awaddr", awaddr, v.exp_awaddr);

    beats = 0; aws = 0; cyc = 0; prev_stall = 0;
    prev_data = '0; prev_last = 1'b0;
    while (!bready && cyc < 200) begin
      awready = (cyc >= v.aw_delay);
      wready  = v.rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wvalid && prev_stall) begin
        chk("wdata stable while stalled", wdata, prev_data);
        chk("wlast stable while stalled", wlast, prev_last);
      end
      if (wvalid) begin
        if (wready) begin
          chk("wdata beat", wdata, word_of(v.pat, beats));
          chk("wlast beat", wlast, (beats == LW - 1));
          if (!v.rand_w && beats == LW - 1) chk("last beat latency", cyc, LW - 1);
          beats++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_data  = wdata;
          prev_last  = wlast;
        end
      end
      if (awvalid && awready) begin
        aws++;
        if (v.w_first) chk("W beats done before AW", beats, LW);
      end
      @(negedge clk);
      cyc++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    chk("RESP reached", bready, 1);
    chk("W beat count", beats, LW);
    chk("AW handshake count", aws, 1);
    chk("awvalid low in RESP", awvalid, 0);
    chk("wvalid low in RESP", wvalid, 0);

    bvalid = 1'b1;
    bresp  = v.bresp;
    #1;
    chk("bus_err in B cycle", bus_err, v.exp_err);
    chk("chk_hit in B cycle", chk_hit, 1);
    @(posedge clk);
    #1;
    bvalid = 1'b0;
    bresp  = 2'b00;
    @(negedge clk);
    chk("bus_err after B", bus_err, 0);
    chk("busy after B", busy, 0);
    chk("wb_ready after B", wb_ready, 1);
    chk("chk_hit after B", chk_hit, 0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h1FC0_0024, 32'h1111_1111, 0,  0, 0, 2'b00, 32'h1FC0_0020, 0};
    vecs[1] = '{32'h0000_1000, 32'h0101_0101, 12, 0, 1, 2'b00, 32'h0000_1000, 0};
    vecs[2] = '{32'hABCD_EF7F, 32'h0F0F_0F0F, 3,  1, 0, 2'b00, 32'hABCD_EF60, 0};
    vecs[3] = '{32'h8000_1040, 32'h2222_0000, 0,  0, 0, 2'b10, 32'h8000_1040, 1};
    vecs[4] = '{32'h7654_321F, 32'h0000_0003, 7,  0, 0, 2'b00, 32'h7654_3200, 0};
    vecs[5] = '{32'hFFFF_FFE0, 32'h1234_5678, 2,  1, 0, 2'b11, 32'hFFFF_FFE0, 1};

    resetn   = 1'b0;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    chk_addr = '0;
    awready  = 1'b0;
    wready   = 1'b0;
    bid      = 4'd1;
    bresp    = 2'b00;
    bvalid   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state and constant fields
    chk("reset wb_ready", wb_ready, 1);
    chk("reset awvalid", awvalid, 0);
    chk("reset wvalid", wvalid, 0);
    chk("reset bready", bready, 0);
    chk("reset busy", busy, 0);
    chk("reset chk_hit", chk_hit, 0);
    chk("reset bus_err", bus_err, 0);
    chk("awlen", awlen, 8'd7);
    chk("awsize", awsize, 3'b010);
    chk("awburst", awburst, 2'b01);
    chk("wstrb", wstrb, 4'hF);
    chk("awid", awid, 4'd1);
    chk("wid", wid, 4'd1);
    resetn = 1'b1;
    @(negedge clk);

    // Stray B response while idle is ignored
    bvalid = 1'b1;
    bresp  = 2'b10;
    @(negedge clk);
    chk("bready low in IDLE", bready, 0);
    chk("no bus_err in IDLE", bus_err, 0);
    chk("stay idle on stray B", wb_ready, 1);
    bvalid = 1'b0;
    bresp  = 2'b00;

    // Table-driven bursts; entry 4 follows the error burst back-to-back
    for (int k = 0; k < 6; k++) do_burst(vecs[k]);

    // Forwarding and mid-burst reset
    chk_addr = 32'h8000_105C;
    offer(32'h8000_1040, 32'h5A5A_0001);
    awready = 1'b0;
    wready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pre-reset wdata", wdata, word_of(32'h5A5A_0001, i));
      @(negedge clk);
    end
    wready = 1'b0;
    chk("chk_hit same line", chk_hit, 1);
    chk_addr = 32'h8000_1060;
    #1;
    chk("chk_hit next line", chk_hit, 0);
    chk("wdata at beat 3", wdata, word_of(32'h5A5A_0001, 3));
    chk_addr = 32'h8000_105C;
    #1;
    resetn = 1'b0;
    #1;
    chk("async reset awvalid", awvalid, 0);
    chk("async reset wvalid", wvalid, 0);
    chk("async reset busy", busy, 0);
    chk("async reset chk_hit", chk_hit, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("wb_ready after reset", wb_ready, 1);
    do_burst(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
